// File: rtl/midi_note_decoder.sv
// midi_note_decoder
//   Monophonic MIDI front end. Parses the raw byte stream from the UART
//   receiver (running status, real-time interleave, system-common abort)
//   and produces one-cycle note_on / note_off strobes plus held note,
//   velocity and gate for the envelope generator and oscillator pitch path.
//
// Ports
//   clk       in   system clock
//   rst       in   synchronous active-high reset
//   rx_data   in   [7:0] received MIDI byte
//   rx_valid  in   rx_data is valid this cycle
//   note_on   out  one-cycle strobe, note started or retriggered
//   note_off  out  one-cycle strobe, current note released
//   gate      out  high while a note is held
//   note      out  [6:0] current/last note number
//   velocity  out  [6:0] velocity of the last accepted note-on
//
// Running-status kind
//   state     | meaning
//   K_NONE    | no usable status; data bytes ignored
//   K_NOTE_ON | 0x9n on our channel
//   K_NOTE_OFF| 0x8n on our channel
//   K_CC      | 0xBn on our channel
//   K_SKIP1   | one-data-byte message to be swallowed (0xCn, 0xDn)
//   K_SKIP2   | two-data-byte message to be swallowed
// Phase
//   P_DATA1   | next data byte is the first of the message
//   P_DATA2   | next data byte completes the message

module midi_note_decoder #(
  parameter logic [3:0] CHANNEL = 4'd0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  output logic       note_on,
  output logic       note_off,
  output logic       gate,
  output logic [6:0] note,
  output logic [6:0] velocity
);

  typedef enum logic [2:0] {
    K_NONE, K_NOTE_ON, K_NOTE_OFF, K_CC, K_SKIP1, K_SKIP2
  } kind_t;

  typedef enum logic {P_DATA1, P_DATA2} phase_t;

  kind_t      kind_q,     kind_d;
  phase_t     phase_q,    phase_d;
  logic [6:0] d1_q,       d1_d;
  logic       gate_q,     gate_d;
  logic [6:0] note_q,     note_d;
  logic [6:0] velocity_q, velocity_d;
  logic       note_on_q,  note_on_d;
  logic       note_off_q, note_off_d;

  logic       ch_match;
  logic [6:0] d2;
  logic       release_hit;

  assign ch_match    = (rx_data[3:0] == CHANNEL);
  assign d2          = rx_data[6:0];
  assign release_hit = gate_q && (d1_q == note_q);

  always_comb begin
    kind_d     = kind_q;
    phase_d    = phase_q;
    d1_d       = d1_q;
    gate_d     = gate_q;
    note_d     = note_q;
    velocity_d = velocity_q;
    note_on_d  = 1'b0;
    note_off_d = 1'b0;

    if (rx_valid) begin
      if (rx_data[7]) begin
        // 0xF8-0xFF real-time bytes leave the parser untouched
        if (rx_data[7:3] != 5'b11111) begin
          phase_d = P_DATA1;
          case (rx_data[7:4])
            4'h8:    kind_d = ch_match ? K_NOTE_OFF : K_SKIP2;
            4'h9:    kind_d = ch_match ? K_NOTE_ON  : K_SKIP2;
            4'hB:    kind_d = ch_match ? K_CC       : K_SKIP2;
            4'hC,
            4'hD:    kind_d = K_SKIP1;
            4'hF:    kind_d = K_NONE;
            default: kind_d = K_SKIP2;
          endcase
        end
      end else if (kind_q != K_NONE && kind_q != K_SKIP1) begin
        if (phase_q == P_DATA1) begin
          d1_d    = rx_data[6:0];
          phase_d = P_DATA2;
        end else begin
          phase_d = P_DATA1;
          case (kind_q)
            K_NOTE_ON: begin
              if (d2 != 7'd0) begin
                note_d     = d1_q;
                velocity_d = d2;
                gate_d     = 1'b1;
                note_on_d  = 1'b1;
              end else if (release_hit) begin
                gate_d     = 1'b0;
                note_off_d = 1'b1;
              end
            end
            K_NOTE_OFF: begin
              if (release_hit) begin
                gate_d     = 1'b0;
                note_off_d = 1'b1;
              end
            end
            K_CC: begin
              // 120 = all sound off, 123 = all notes off
              if (gate_q && (d1_q == 7'd120 || d1_q == 7'd123)) begin
                gate_d     = 1'b0;
                note_off_d = 1'b1;
              end
            end
            default: ;
          endcase
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      kind_q     <= K_NONE;
      phase_q    <= P_DATA1;
      d1_q       <= 7'd0;
      gate_q     <= 1'b0;
      note_q     <= 7'd0;
      velocity_q <= 7'd0;
      note_on_q  <= 1'b0;
      note_off_q <= 1'b0;
    end else begin
      kind_q     <= kind_d;
      phase_q    <= phase_d;
      d1_q       <= d1_d;
      gate_q     <= gate_d;
      note_q     <= note_d;
      velocity_q <= velocity_d;
      note_on_q  <= note_on_d;
      note_off_q <= note_off_d;
    end
  end

  assign note_on  = note_on_q;
  assign note_off = note_off_q;
  assign gate     = gate_q;
  assign note     = note_q;
  assign velocity = velocity_q;

endmodule

// File: tb/tb_midi_note_decoder.sv
// Bench for midi_note_decoder: a message-level reference model (last status
// byte plus a buffer of collected data bytes) compared every cycle, directed
// sequences with literal expectations, then randomized byte streams.
module tb_midi_note_decoder;

  localparam logic [3:0] CHANNEL = 4'd0;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [7:0] rx_data = 8'd0;
  logic       rx_valid = 1'b0;
  logic       note_on, note_off, gate;
  logic [6:0] note, velocity;

  int n_cmp = 0;
  int n_err = 0;
  bit cmp_en = 1'b0;

  midi_note_decoder #(.CHANNEL(CHANNEL)) dut (
    .clk      (clk),
    .rst      (rst),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .note_on  (note_on),
    .note_off (note_off),
    .gate     (gate),
    .note     (note),
    .velocity (velocity)
  );

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  int         m_rs = -1;          // last channel status byte, -1 = none
  logic [7:0] m_buf[$];
  logic       m_on = 0, m_off = 0, m_gate = 0;
  logic [6:0] m_note = 0, m_vel = 0;

  function automatic int msg_len(input int st);
    return (((st >> 4) == 12) || ((st >> 4) == 13)) ? 1 : 2;
  endfunction

  function void execute(input int st, input logic [7:0] a, input logic [7:0] b);
    int hi;
    bit ours;
    hi   = st >> 4;
    ours = ((st & 15) == int'(CHANNEL));
    if (!ours) return;
    if (hi == 9 && b != 0) begin
      m_note = a[6:0]; m_vel = b[6:0]; m_gate = 1; m_on = 1;
    end else if (hi == 8 || hi == 9) begin
      if (m_gate && a[6:0] == m_note) begin m_gate = 0; m_off = 1; end
    end else if (hi == 11) begin
      if (m_gate && (a == 120 || a == 123)) begin m_gate = 0; m_off = 1; end
    end
  endfunction

  always @(posedge clk) begin
    logic [7:0] b;
    m_on = 0; m_off = 0;
    if (rst) begin
      m_rs = -1; m_buf.delete();
      m_gate = 0; m_note = 0; m_vel = 0;
    end else if (rx_valid) begin
      b = rx_data;
      if (b >= 8'hF8) begin
      end else if (b >= 8'hF0) begin
        m_rs = -1; m_buf.delete();
      end else if (b[7]) begin
        m_rs = int'(b); m_buf.delete();
      end else if (m_rs >= 0) begin
        m_buf.push_back(b);
        if (m_buf.size() == msg_len(m_rs)) begin
          if (msg_len(m_rs) == 2) execute(m_rs, m_buf[0], m_buf[1]);
          m_buf.delete();
        end
      end
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      n_cmp++;
      if (note_on !== m_on || note_off !== m_off || gate !== m_gate ||
          note !== m_note || velocity !== m_vel) begin
        n_err++;
        $display("FAIL model t=%0t on/off/gate/note/vel actual %b/%b/%b/%h/%h required %b/%b/%b/%h/%h",
                 $time, note_on, note_off, gate, note, velocity,
                 m_on, m_off, m_gate, m_note, m_vel);
      end
    end
  end

  // ---------------- directed helpers ----------------
  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s actual %0h required %0h", name, act, exp);
    end
  endtask

  task automatic send(input logic [7:0] b);
    rx_data = b; rx_valid = 1'b1;
    @(posedge clk); #1;
    rx_valid = 1'b0;
  endtask

  task automatic idle();
    rx_valid = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic chk_out(input string name, input int on, input int off,
                         input int g, input int n, input int v);
    chk({name, ".note_on"},  int'(note_on),  on);
    chk({name, ".note_off"}, int'(note_off), off);
    chk({name, ".gate"},     int'(gate),     g);
    chk({name, ".note"},     int'(note),     n);
    chk({name, ".velocity"}, int'(velocity), v);
  endtask

  function automatic logic [7:0] rand_byte();
    logic [7:0] nn[5];
    nn[0] = 8'h3C; nn[1] = 8'h40; nn[2] = 8'h00; nn[3] = 8'd120; nn[4] = 8'd123;
    case ($urandom_range(0, 11))
      0:       return 8'h90 | 8'($urandom_range(0, 1));
      1:       return 8'h80 | 8'($urandom_range(0, 1));
      2:       return 8'hB0 | 8'($urandom_range(0, 1));
      3:       return 8'hC0 | 8'($urandom_range(0, 31));   // Cn / Dn
      4:       return 8'hA0 | 8'($urandom_range(0, 15));
      5:       return 8'hF0 | 8'($urandom_range(0, 15));   // common + real-time
      6, 7:    return nn[$urandom_range(0, 4)];
      default: return 8'($urandom_range(0, 127));
    endcase
  endfunction

  initial begin
    rst = 1'b1;
    @(posedge clk); @(posedge clk); #1;
    cmp_en = 1'b1;
    chk_out("reset", 0, 0, 0, 0, 0);
    rst = 1'b0;

    send(8'h90); send(8'h3C);
    chk("pre_strobe.note_on", int'(note_on), 0);
    send(8'h64);
    chk_out("basic_on", 1, 0, 1, 8'h3C, 8'h64);
    idle();
    chk("strobe_one_cycle", int'(note_on), 0);

    send(8'h3C); send(8'h00);
    chk_out("running_off", 0, 1, 0, 8'h3C, 8'h64);
    idle();

    send(8'h91); send(8'h3C); send(8'h64);
    chk_out("wrong_ch", 0, 0, 0, 8'h3C, 8'h64);
    send(8'hC0); send(8'h05); send(8'h40);
    chk_out("skip1", 0, 0, 0, 8'h3C, 8'h64);

    send(8'h90); send(8'hF8); send(8'h3C); send(8'hFE); send(8'h50);
    chk_out("realtime", 1, 0, 1, 8'h3C, 8'h50);

    send(8'h90); send(8'h40); send(8'h40);
    chk_out("retrigger", 1, 0, 1, 8'h40, 8'h40);
    send(8'h80); send(8'h3C); send(8'h40);
    chk_out("off_stale", 0, 0, 1, 8'h40, 8'h40);
    send(8'h80); send(8'h40); send(8'h40);
    chk_out("off_current", 0, 1, 0, 8'h40, 8'h40);
    send(8'hB0); send(8'h7B); send(8'h00);
    chk_out("cc_gate_low", 0, 0, 0, 8'h40, 8'h40);

    send(8'h90); send(8'h3C); send(8'h64);
    send(8'hB0); send(8'd120); send(8'h00);
    chk_out("cc120", 0, 1, 0, 8'h3C, 8'h64);

    send(8'h90); send(8'h3C);
    rst = 1'b1; @(posedge clk); #1; rst = 1'b0;
    chk_out("mid_reset", 0, 0, 0, 0, 0);
    send(8'h64);
    chk_out("post_reset_data", 0, 0, 0, 0, 0);
    send(8'h90); send(8'h3C); send(8'h64);
    chk_out("post_reset_msg", 1, 0, 1, 8'h3C, 8'h64);

    for (int i = 0; i < 4000; i++) begin
      rst      = ($urandom_range(0, 299) == 0);
      rx_valid = ($urandom_range(0, 3) != 0);
      rx_data  = rand_byte();
      @(posedge clk); #1;
    end
    rst = 1'b0; rx_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    cmp_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
